// File: rtl/decoder_3to8_ack.sv
// ---------------------------------------------------------------------------
// decoder_3to8_ack
//   Sequential 3-to-8 decoder with acknowledge hold. An encoded index Y,
//   qualified by V, is turned into a one-hot acknowledge D that is held for
//   HOLD cycles, followed by an idle gap of GAP cycles before the next code
//   can be accepted. Accepted codes are counted and requests arriving while
//   busy set a sticky overrun flag.
//
// Parameters
//   HOLD : cycles D/DV stay asserted per accepted code (1..255)
//   GAP  : idle cycles after DV falls before BUSY deasserts (0..255)
//
// Ports
//   clk  : clock, rising edge active
//   rst  : asynchronous active-high reset
//   Y    : encoded index (3 bits)
//   V    : Y valid
//   D    : one-hot acknowledge, zero when DV = 0
//   DV   : D valid
//   BUSY : high while holding or gapping; code accepted only when low
//   CNT  : accepted-code count, modulo 256
//   OVR  : sticky overrun flag, cleared only by rst
// ---------------------------------------------------------------------------
module decoder_3to8_ack #(
    parameter int unsigned HOLD = 4,
    parameter int unsigned GAP  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] Y,
    input  logic       V,
    output logic [7:0] D,
    output logic       DV,
    output logic       BUSY,
    output logic [7:0] CNT,
    output logic       OVR
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLDING = 2'd1,
        GAPPING = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);
    localparam logic [7:0] GAP_LOAD  = 8'((GAP == 0) ? 0 : GAP - 1);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [7:0] d_d;
    logic       dv_d;
    logic       busy_d;
    logic [7:0] cnt_d;
    logic       ovr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            D       <= '0;
            DV      <= 1'b0;
            BUSY    <= 1'b0;
            CNT     <= '0;
            OVR     <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            D       <= d_d;
            DV      <= dv_d;
            BUSY    <= busy_d;
            CNT     <= cnt_d;
            OVR     <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        d_d     = D;
        dv_d    = DV;
        cnt_d   = CNT;
        // BUSY mirrors state_q != IDLE, so a request seen while BUSY is an
        // overrun, including the edge on which the FSM returns to IDLE.
        ovr_d   = OVR | (V & BUSY);

        unique case (state_q)
            IDLE: begin
                if (V) begin
                    d_d     = 8'b1 << Y;
                    dv_d    = 1'b1;
                    cnt_d   = CNT + 8'd1;
                    timer_d = HOLD_LOAD;
                    state_d = HOLDING;
                end
            end
            HOLDING: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 8'd1;
                end else begin
                    d_d  = '0;
                    dv_d = 1'b0;
                    if (GAP == 0) begin
                        state_d = IDLE;
                    end else begin
                        timer_d = GAP_LOAD;
                        state_d = GAPPING;
                    end
                end
            end
            GAPPING: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 8'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                d_d     = '0;
                dv_d    = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule
